// File: rtl/mmio_uart_tx_if.sv
// MMIO single-port bus bundle: word address, byte enables, strobe, write data, read data.
// Latency: none (pure wiring); read data is registered inside the slave.
// Backpressure: none; the slave accepts every strobe in the cycle it is presented.
interface mmio_uart_tx_if;
    logic [13:0] address;
    logic [3:0]  byteena;
    logic        clken;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q;

    modport master (output address, output byteena, output clken, output data, output wren, input q);
    modport slave  (input address, input byteena, input clken, input data, input wren, output q);
endinterface

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TX FIFO plus 8N1 serialiser with a programmable clocks-per-bit divisor.
// Latency: reads return on q one cycle after the access; a TXDATA push into an idle block starts the frame one cycle later.
// Backpressure: none on the bus; a push into a full FIFO is dropped and flagged in the sticky OVF bit.
module mmio_uart_tx #(
    parameter logic [13:0] BASE_WORD   = 14'h0010,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic           clk,
    input  logic           reset_n,
    mmio_uart_tx_if.slave  bus,
    output logic           uart_tx,
    output logic           irq_tx_empty
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      sh_q, sh_d;
    logic [15:0]     div_lat_q, div_lat_d;
    logic            tx_q, tx_d;
    logic [31:0]     q_q, q_d;
    logic [15:0]     divisor_q, divisor_d;
    logic            ovf_q, ovf_d;
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      mem_q [FIFO_DEPTH];

    logic [13:0]     offset;
    logic            hit, wr_en, rd_en, sel_tx, sel_st, sel_div;
    logic            fifo_empty, fifo_full, expire, pop, start_frame;
    logic            push_req, push_ok;
    logic [15:0]     eff_div;
    logic [31:0]     status, rdata;
    logic            unused_bits;

    // Address decode relative to the block base; offsets below the base wrap to large values and miss.
    assign offset     = bus.address - BASE_WORD;
    assign hit        = offset < 14'd3;
    assign wr_en      = bus.clken & bus.wren;
    assign rd_en      = bus.clken & ~bus.wren;
    assign sel_tx     = hit & (offset == 14'd0);
    assign sel_st     = hit & (offset == 14'd1);
    assign sel_div    = hit & (offset == 14'd2);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign expire     = (cnt_q == 16'd0);
    assign eff_div    = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
    assign unused_bits = ^{bus.data[31:16], bus.byteena[3:2]};

    assign uart_tx      = tx_q;
    assign irq_tx_empty = fifo_empty & (state_q == S_IDLE);
    assign bus.q        = q_q;

    // Serialiser next-state: one bit per divisor period, LSB first, back-to-back frames from STOP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sh_d        = sh_q;
        div_lat_d   = div_lat_q;
        tx_d        = tx_q;
        start_frame = 1'b0;
        case (state_q)
            S_IDLE: begin
                start_frame = ~fifo_empty;
            end
            S_START: begin
                if (expire) begin
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                    bit_d   = 3'd0;
                    cnt_d   = div_lat_q - 16'd1;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (expire) begin
                    cnt_d = div_lat_q - 16'd1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d  = sh_q[0];
                        sh_d  = {1'b0, sh_q[7:1]};
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (expire) begin
                    start_frame = ~fifo_empty;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame start: pop the head and freeze the divisor so mid-frame DIVISOR writes wait.
        if (start_frame) begin
            sh_d      = mem_q[rptr_q];
            div_lat_d = eff_div;
            cnt_d     = eff_div - 16'd1;
            tx_d      = 1'b0;
            state_d   = S_START;
        end
    end

    assign pop = start_frame;

    // Register file and FIFO bookkeeping: a pop in the same cycle frees room for a push into a full FIFO.
    always_comb begin
        push_req  = wr_en & sel_tx & bus.byteena[0];
        push_ok   = push_req & (~fifo_full | pop);
        wptr_d    = wptr_q + AW'(push_ok);
        rptr_d    = rptr_q + AW'(pop);
        count_d   = count_q + CW'(push_ok) - CW'(pop);
        ovf_d     = ovf_q;
        if (push_req & ~push_ok) begin
            ovf_d = 1'b1;
        end else if (wr_en & sel_st & bus.byteena[0] & bus.data[3]) begin
            ovf_d = 1'b0;
        end
        divisor_d = divisor_q;
        if (wr_en & sel_div & bus.byteena[0]) divisor_d[7:0]  = bus.data[7:0];
        if (wr_en & sel_div & bus.byteena[1]) divisor_d[15:8] = bus.data[15:8];
        status             = '0;
        status[0]          = fifo_full;
        status[1]          = fifo_empty;
        status[2]          = (state_q != S_IDLE);
        status[3]          = ovf_q;
        status[8 +: CW]    = count_q;
        rdata = '0;
        if (sel_st)  rdata = status;
        if (sel_div) rdata = {16'h0000, divisor_q};
        q_d = rd_en ? rdata : q_q;
    end

    // State registers with synchronous active-low reset; reset aborts any frame and flushes the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            div_lat_q <= DEFAULT_DIV;
            tx_q      <= 1'b1;
            q_q       <= '0;
            divisor_q <= DEFAULT_DIV;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            div_lat_q <= div_lat_d;
            tx_q      <= tx_d;
            q_q       <= q_d;
            divisor_q <= divisor_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
        end
    end

    // FIFO storage; not reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= bus.data[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic uart_tx, irq_tx_empty;
    int   total = 0;
    int   bad = 0;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_WORD(14'h0010), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .uart_tx(uart_tx), .irq_tx_empty(irq_tx_empty));

    always #5 clk = ~clk;

    // Reference model: frames are described by start edge, divisor and byte; line level is derived arithmetically.
    int          edge_n = 0;
    logic [7:0]  mfifo[$];
    bit          m_active = 0;
    int          m_fstart = 0, m_fdiv = 1;
    logic [7:0]  m_fbyte = 8'h00;
    bit          m_ovf = 0;
    logic [15:0] m_div = 16'd434;
    logic [31:0] exp_q = 32'h0;
    logic        exp_tx = 1'b1, exp_irq = 1'b1;
    int          line_err = 0, irq_err = 0, q_err = 0, irq_low = 0;

    always @(posedge clk) begin
        int pre_size, off, j, b;
        bit pop_now, frame_end;
        logic [31:0] st;
        if (!reset_n) begin
            mfifo.delete();
            m_active = 0;
            m_ovf    = 0;
            m_div    = 16'd434;
            exp_q    = 32'h0;
        end else begin
            pre_size  = mfifo.size();
            off       = int'(bus.address) - 16;
            st        = 32'h0;
            st[0]     = (pre_size == 8);
            st[1]     = (pre_size == 0);
            st[2]     = m_active;
            st[3]     = m_ovf;
            st[14:8]  = 7'(pre_size);
            frame_end = m_active && (edge_n == m_fstart + 10 * m_fdiv);
            pop_now   = (!m_active || frame_end) && pre_size > 0;
            if (bus.clken && !bus.wren)
                exp_q = (off == 1) ? st : (off == 2) ? {16'h0, m_div} : 32'h0;
            if (pop_now) begin
                m_fbyte  = mfifo.pop_front();
                m_fdiv   = (m_div == 16'd0) ? 1 : int'(m_div);
                m_fstart = edge_n;
                m_active = 1;
            end else if (frame_end) begin
                m_active = 0;
            end
            if (bus.clken && bus.wren) begin
                if (off == 0 && bus.byteena[0]) begin
                    if (pre_size == 8 && !pop_now) m_ovf = 1;
                    else mfifo.push_back(bus.data[7:0]);
                end
                if (off == 1 && bus.byteena[0] && bus.data[3]) m_ovf = 0;
                if (off == 2 && bus.byteena[0]) m_div[7:0]  = bus.data[7:0];
                if (off == 2 && bus.byteena[1]) m_div[15:8] = bus.data[15:8];
            end
        end
        if (m_active) begin
            j = edge_n - m_fstart;
            b = j / m_fdiv;
            exp_tx = (b == 0) ? 1'b0 : (b <= 8) ? m_fbyte[b-1] : 1'b1;
        end else begin
            exp_tx = 1'b1;
        end
        exp_irq = (mfifo.size() == 0) && !m_active;
        edge_n++;
    end

    // Continuous line/irq/q comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (uart_tx !== exp_tx) line_err++;
        if (irq_tx_empty !== exp_irq) irq_err++;
        if (bus.q !== exp_q) q_err++;
        if (irq_tx_empty === 1'b0) irq_low++;
    end

    task automatic nop();
        @(negedge clk);
        bus.clken = 1'b0;
        bus.wren  = 1'b0;
    endtask

    task automatic wr(input int off, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        bus.address = 14'(16 + off);
        bus.byteena = be;
        bus.data    = d;
        bus.wren    = 1'b1;
        bus.clken   = 1'b1;
    endtask

    task automatic rd(input int off, output logic [31:0] v);
        @(negedge clk);
        bus.address = 14'(16 + off);
        bus.wren    = 1'b0;
        bus.clken   = 1'b1;
        @(negedge clk);
        bus.clken = 1'b0;
        v = bus.q;
    endtask

    task automatic wait_idle(input int maxc, output bit ok);
        ok = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            bus.clken = 1'b0;
            if (irq_tx_empty === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.clken = 1'b0;
        reset_n   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        apply_reset();
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        total++; if (irq_tx_empty !== 1'b1) begin bad++; $display("FAIL reset_irq got=%b exp=1", irq_tx_empty); end
        rd(1, v);
        total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL reset_status got=%h exp=%h", v, 32'h2); end
        rd(2, v);
        total++; if (v !== 32'd434) begin bad++; $display("FAIL reset_divisor got=%0d exp=434", v); end
        rd(0, v);
        total++; if (v !== 32'h0) begin bad++; $display("FAIL txdata_read got=%h exp=0", v); end
    endtask

    task automatic test_frame_55();
        logic [9:0] pat;
        int werr, ierr, le0;
        pat  = 10'b10_1010_1010;
        werr = 0;
        ierr = 0;
        le0  = line_err;
        wr(2, 4'b0011, 32'd4);
        wr(0, 4'b0001, 32'h55);
        nop();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (uart_tx !== pat[i/4]) werr++;
            if (irq_tx_empty !== 1'b0) ierr++;
        end
        total++; if (werr != 0) begin bad++; $display("FAIL frame55_wave bad_samples=%0d exp=0", werr); end
        total++; if (ierr != 0) begin bad++; $display("FAIL frame55_busy bad_samples=%0d exp=0", ierr); end
        @(negedge clk);
        total++; if (irq_tx_empty !== 1'b1) begin bad++; $display("FAIL frame55_irq_end got=%b exp=1", irq_tx_empty); end
        total++; if (line_err != le0) begin bad++; $display("FAIL frame55_model got=%0d exp=%0d", line_err, le0); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        bit ok;
        int le0, il0;
        apply_reset();
        wr(2, 4'b0011, 32'd1);
        nop();
        le0 = line_err;
        il0 = irq_low;
        for (int i = 0; i < 10; i++) wr(0, 4'b0001, $urandom);
        rd(1, v);
        total++; if (v !== 32'h0000_080D) begin bad++; $display("FAIL ovf_status got=%h exp=%h", v, 32'h80D); end
        wr(1, 4'b0010, 32'h8);
        rd(1, v);
        total++; if (v[3] !== 1'b1) begin bad++; $display("FAIL ovf_wrong_lane got=%b exp=1", v[3]); end
        wr(1, 4'b0001, 32'h8);
        rd(1, v);
        total++; if (v[3] !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", v[3]); end
        wait_idle(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_drain_timeout got=0 exp=1"); end
        total++; if (irq_low - il0 != 91) begin bad++; $display("FAIL ovf_busy_cycles got=%0d exp=91", irq_low - il0); end
        total++; if (line_err != le0) begin bad++; $display("FAIL ovf_line got=%0d exp=%0d", line_err, le0); end
    endtask

    task automatic test_full_pop_same_cycle();
        logic [31:0] v;
        bit ok;
        int le0, il0;
        apply_reset();
        wr(2, 4'b0011, 32'd1);
        nop();
        le0 = line_err;
        il0 = irq_low;
        for (int i = 0; i < 9; i++) wr(0, 4'b0001, $urandom);
        nop();
        nop();
        wr(0, 4'b0001, $urandom);
        rd(1, v);
        total++; if (v !== 32'h0000_0805) begin bad++; $display("FAIL fullpop_status got=%h exp=%h", v, 32'h805); end
        wait_idle(400, ok);
        total++; if (!ok) begin bad++; $display("FAIL fullpop_drain_timeout got=0 exp=1"); end
        total++; if (irq_low - il0 != 101) begin bad++; $display("FAIL fullpop_busy_cycles got=%0d exp=101", irq_low - il0); end
        total++; if (line_err != le0) begin bad++; $display("FAIL fullpop_line got=%0d exp=%0d", line_err, le0); end
    endtask

    task automatic test_divisor();
        logic [31:0] v;
        bit ok;
        int le0, il0;
        apply_reset();
        le0 = line_err;
        wr(2, 4'b0011, 32'd0);
        rd(2, v);
        total++; if (v !== 32'd0) begin bad++; $display("FAIL div0_read got=%h exp=0", v); end
        il0 = irq_low;
        wr(0, 4'b0001, $urandom);
        nop();
        wait_idle(100, ok);
        total++; if (!ok || irq_low - il0 != 11) begin bad++; $display("FAIL div0_frame_cycles got=%0d exp=11", irq_low - il0); end
        wr(2, 4'b0011, 32'd4);
        nop();
        il0 = irq_low;
        wr(0, 4'b0001, $urandom);
        for (int i = 0; i < 5; i++) nop();
        wr(2, 4'b0011, 32'd8);
        wr(0, 4'b0001, $urandom);
        nop();
        wait_idle(400, ok);
        total++; if (!ok || irq_low - il0 != 121) begin bad++; $display("FAIL div_change_cycles got=%0d exp=121", irq_low - il0); end
        wr(2, 4'b0010, 32'h0000_AB00);
        rd(2, v);
        total++; if (v !== 32'h0000_AB08) begin bad++; $display("FAIL div_lane_write got=%h exp=%h", v, 32'hAB08); end
        total++; if (line_err != le0) begin bad++; $display("FAIL div_line got=%0d exp=%0d", line_err, le0); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] v;
        int lows;
        apply_reset();
        wr(2, 4'b0011, 32'd4);
        for (int i = 0; i < 4; i++) wr(0, 4'b0001, $urandom);
        for (int i = 0; i < 12; i++) nop();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", uart_tx); end
        reset_n = 1'b1;
        rd(1, v);
        total++; if (v !== 32'h0000_0002) begin bad++; $display("FAIL rstmid_status got=%h exp=%h", v, 32'h2); end
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || irq_tx_empty !== 1'b1) lows++;
        end
        total++; if (lows != 0) begin bad++; $display("FAIL rstmid_residual got=%0d exp=0", lows); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        bit ok;
        int n, op;
        for (int it = 0; it < 6; it++) begin
            wr(2, 4'b0011, 32'($urandom_range(1, 3)));
            n = $urandom_range(4, 14);
            for (int k = 0; k < n; k++) begin
                op = $urandom_range(0, 5);
                case (op)
                    0, 1: wr(0, 4'b0001, $urandom);
                    2:    wr(0, 4'($urandom_range(0, 15)), $urandom);
                    3:    rd(int'($urandom_range(0, 6)) - 2, v);
                    4:    wr(1, 4'($urandom_range(0, 15)), $urandom);
                    default: nop();
                endcase
            end
            nop();
            wait_idle(2000, ok);
            total++; if (!ok) begin bad++; $display("FAIL random_drain_timeout iter=%0d got=0 exp=1", it); end
        end
        total++; if (line_err != 0) begin bad++; $display("FAIL line_vs_model got=%0d exp=0", line_err); end
        total++; if (irq_err != 0) begin bad++; $display("FAIL irq_vs_model got=%0d exp=0", irq_err); end
        total++; if (q_err != 0) begin bad++; $display("FAIL q_vs_model got=%0d exp=0", q_err); end
    endtask

    initial begin
        bus.address = '0;
        bus.byteena = '0;
        bus.data    = '0;
        bus.wren    = 1'b0;
        bus.clken   = 1'b0;
        test_reset();
        test_frame_55();
        test_overflow();
        test_full_pop_same_cycle();
        test_divisor();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
